// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage enable/clear strobes and PC enable.
// Optional multi-cycle mul/div stall enabled by defining PIPE_CTRL_MULDIV_STALL_EN.
//
// state | meaning
// RUN   | normal flow; halt, mul/div, branch and load-use events evaluated
// BUSY  | mul/div occupying EX; front end frozen, EX/MEM fed bubbles
// HALT  | front end frozen, older instructions drain; left only by reset
module pipe_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch_taken,
  input  logic       ex_muldiv_start,
  input  logic       ex_halt,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_clr,
  output logic       idex_en,
  output logic       idex_clr,
  output logic       exmem_en,
  output logic       exmem_clr,
  output logic       memwb_en,
  output logic       memwb_clr,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_BUSY = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_lu;
  logic   w_chk_br_lu;

  assign w_lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

`ifdef PIPE_CTRL_MULDIV_STALL_EN
  localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= w_cnt_nxt;
  end
`else
  // Mul/div treated as single-cycle: its start flag and sizing parameters have no effect.
  localparam logic LP_CFG_OK = (MULDIV_CYCLES >= 2) && (CNT_W > 0);
  logic w_unused;
  assign w_unused = ^{ex_muldiv_start, LP_CFG_OK};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_clr    = 1'b0;
    idex_en     = 1'b1;
    idex_clr    = 1'b0;
    exmem_en    = 1'b1;
    exmem_clr   = 1'b0;
    memwb_en    = 1'b1;
    memwb_clr   = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    w_chk_br_lu = 1'b0;
    w_state_nxt = r_state;
`ifdef PIPE_CTRL_MULDIV_STALL_EN
    w_cnt_nxt   = r_cnt;
`endif

    if (!rst_n) begin
      // Flush every pipeline register on the reset edge.
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
      memwb_clr = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (ex_halt) begin
            ifid_clr    = 1'b1;
            idex_clr    = 1'b1;
            pc_en       = 1'b0;
            w_state_nxt = ST_HALT;
          end
`ifdef PIPE_CTRL_MULDIV_STALL_EN
          else if (ex_muldiv_start) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_clr   = 1'b1;
            w_cnt_nxt   = LP_CNT_LOAD;
            w_state_nxt = ST_BUSY;
          end
`endif
          else begin
            w_chk_br_lu = 1'b1;
          end
        end

        ST_BUSY: begin
`ifdef PIPE_CTRL_MULDIV_STALL_EN
          if (r_cnt != '0) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_clr = 1'b1;
            busy      = 1'b1;
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            // Release cycle: the mul/div advances; halt/start are not re-examined here.
            w_chk_br_lu = 1'b1;
            w_state_nxt = ST_RUN;
          end
`else
          w_state_nxt = ST_RUN;
`endif
        end

        ST_HALT: begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          exmem_clr = 1'b1;
          memwb_en  = 1'b1;
          halted    = 1'b1;
        end

        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase

      // Branch wins over load-use: the ID instruction is wrong-path anyway.
      if (w_chk_br_lu) begin
        if (ex_branch_taken) begin
          ifid_clr = 1'b1;
          idex_clr = 1'b1;
          pc_en    = 1'b1;
        end else if (w_lu) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_clr = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// against a cycle-indexed behavioural model.
module tb_pipe_ctrl;

  localparam int MC = 4;
  localparam int CW = 3;
`ifdef PIPE_CTRL_MULDIV_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  // {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, memwb_clr, busy, halted}
  localparam logic [10:0] O_DEF  = 11'b11010101000;
  localparam logic [10:0] O_RST  = 11'b11111111100;
  localparam logic [10:0] O_LU   = 11'b00011101000;
  localparam logic [10:0] O_BR   = 11'b11111101000;
  localparam logic [10:0] O_HEV  = 11'b01111101000;
  localparam logic [10:0] O_MD   = 11'b00000111000;
  localparam logic [10:0] O_BUSY = 11'b00000111010;
  localparam logic [10:0] O_HLTD = 11'b00000111001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_mem_read;
  logic       ex_branch_taken, ex_muldiv_start, ex_halt;
  logic       pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
  logic       exmem_en, exmem_clr, memwb_en, memwb_clr, busy, halted;
  logic [10:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: halted flag and the absolute cycle index of the pending mul/div release.
  int m_now = 0;
  bit m_halted = 1'b0;
  int m_rel = -1;

  always #5 clk = ~clk;

  assign obs = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
                exmem_en, exmem_clr, memwb_en, memwb_clr, busy, halted};

  pipe_ctrl #(.MULDIV_CYCLES(MC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_muldiv_start(ex_muldiv_start), .ex_halt(ex_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr),
    .idex_en(idex_en), .idex_clr(idex_clr), .exmem_en(exmem_en), .exmem_clr(exmem_clr),
    .memwb_en(memwb_en), .memwb_clr(memwb_clr), .busy(busy), .halted(halted)
  );

  function automatic logic [10:0] model_out();
    bit lu, stalled, release_now;
    bit pc, ife, ifc, ide, idc, exe, exc, wbe, wbc, bsy, hlt;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    pc = 1; ife = 1; ifc = 0; ide = 1; idc = 0; exe = 1; exc = 0; wbe = 1; wbc = 0; bsy = 0; hlt = 0;
    stalled     = (m_rel >= 0) && (m_now < m_rel);
    release_now = (m_rel == m_now);
    if (!rst_n) begin
      ifc = 1; idc = 1; exc = 1; wbc = 1;
    end else if (m_halted) begin
      pc = 0; ife = 0; ide = 0; exc = 1; hlt = 1;
    end else if (stalled) begin
      pc = 0; ife = 0; ide = 0; exc = 1; bsy = 1;
    end else if (!release_now && ex_halt) begin
      ifc = 1; idc = 1; pc = 0;
    end else if (!release_now && MD_EN && ex_muldiv_start) begin
      pc = 0; ife = 0; ide = 0; exc = 1;
    end else if (ex_branch_taken) begin
      ifc = 1; idc = 1;
    end else if (lu) begin
      pc = 0; ife = 0; idc = 1;
    end
    return {pc, ife, ifc, ide, idc, exe, exc, wbe, wbc, bsy, hlt};
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      m_halted = 1'b0;
      m_rel    = -1;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (m_rel >= 0 && m_now < m_rel) begin
      m_rel = m_rel;
    end else if (m_rel == m_now) begin
      m_rel = -1;
    end else if (ex_halt) begin
      m_halted = 1'b1;
    end else if (MD_EN && ex_muldiv_start) begin
      m_rel = m_now + MC - 1;
    end
    m_now++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rd = 0;
    id_use_rs = 0; id_use_rt = 0; ex_mem_read = 0;
    ex_branch_taken = 0; ex_muldiv_start = 0; ex_halt = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== O_RST) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, O_RST);
      end
      tick();
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs !== O_DEF) begin
      n_fail++;
      $display("FAIL reset_after: got %b want %b", obs, O_DEF);
    end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
    @(negedge clk);
    n_tests++;
    if (obs !== O_LU) begin
      n_fail++;
      $display("FAIL lu_rs_stall: got %b want %b", obs, O_LU);
    end
    tick();
    idle();
    @(negedge clk);
    n_tests++;
    if (obs !== O_DEF) begin
      n_fail++;
      $display("FAIL lu_one_cycle: got %b want %b", obs, O_DEF);
    end
    tick();
    ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
    @(negedge clk);
    n_tests++;
    if (obs !== O_DEF) begin
      n_fail++;
      $display("FAIL lu_rd0: got %b want %b", obs, O_DEF);
    end
    tick();
    idle();
    ex_mem_read = 1; ex_rd = 9; id_rt = 9; id_use_rt = 1;
    @(negedge clk);
    n_tests++;
    if (obs !== O_LU) begin
      n_fail++;
      $display("FAIL lu_rt_stall: got %b want %b", obs, O_LU);
    end
    tick();
    id_use_rt = 0;
    @(negedge clk);
    n_tests++;
    if (obs !== O_DEF) begin
      n_fail++;
      $display("FAIL lu_rt_unused: got %b want %b", obs, O_DEF);
    end
    tick();
    idle();
  endtask

  task automatic test_branch_lu();
    idle();
    ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 7; id_rs = 7; id_use_rs = 1;
    @(negedge clk);
    n_tests++;
    if (obs !== O_BR) begin
      n_fail++;
      $display("FAIL branch_lu: got %b want %b", obs, O_BR);
    end
    tick();
    idle();
    @(negedge clk);
    n_tests++;
    if (obs !== O_DEF) begin
      n_fail++;
      $display("FAIL branch_after: got %b want %b", obs, O_DEF);
    end
    tick();
  endtask

  task automatic test_muldiv();
    logic [10:0] want [$];
    idle();
    if (MD_EN) begin
      // Single mul/div with ex_halt raised during the stall and release cycles.
      want = '{O_MD, O_BUSY, O_BUSY, O_DEF, O_DEF};
      for (int i = 0; i < want.size(); i++) begin
        ex_muldiv_start = (i == 0);
        ex_halt         = (i >= 1 && i <= 3);
        @(negedge clk);
        n_tests++;
        if (obs !== want[i]) begin
          n_fail++;
          $display("FAIL muldiv[%0d]: got %b want %b", i, obs, want[i]);
        end
        tick();
      end
      idle();
      // Back-to-back: start held high; the second is taken the cycle after release.
      want = '{O_MD, O_BUSY, O_BUSY, O_DEF, O_MD, O_BUSY, O_BUSY, O_DEF, O_DEF};
      for (int i = 0; i < want.size(); i++) begin
        ex_muldiv_start = (i <= 4);
        @(negedge clk);
        n_tests++;
        if (obs !== want[i]) begin
          n_fail++;
          $display("FAIL muldiv_b2b[%0d]: got %b want %b", i, obs, want[i]);
        end
        tick();
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        ex_muldiv_start = (i < 2);
        @(negedge clk);
        n_tests++;
        if (obs !== O_DEF) begin
          n_fail++;
          $display("FAIL muldiv_off[%0d]: got %b want %b", i, obs, O_DEF);
        end
        tick();
      end
    end
    idle();
  endtask

  task automatic test_halt();
    idle();
    ex_halt = 1;
    @(negedge clk);
    n_tests++;
    if (obs !== O_HEV) begin
      n_fail++;
      $display("FAIL halt_event: got %b want %b", obs, O_HEV);
    end
    tick();
    for (int i = 0; i < 20; i++) begin
      ex_halt         = 1'($urandom_range(0, 1));
      ex_branch_taken = 1'($urandom_range(0, 1));
      ex_muldiv_start = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_tests++;
      if (obs !== O_HLTD) begin
        n_fail++;
        $display("FAIL halt_hold[%0d]: got %b want %b", i, obs, O_HLTD);
      end
      tick();
    end
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs !== O_RST) begin
      n_fail++;
      $display("FAIL halt_reset: got %b want %b", obs, O_RST);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs !== O_DEF) begin
      n_fail++;
      $display("FAIL halt_exit: got %b want %b", obs, O_DEF);
    end
    tick();
  endtask

  task automatic test_random();
    logic [10:0] exp;
    for (int i = 0; i < 3000; i++) begin
      rst_n           = (i < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
      ex_halt         = ($urandom_range(0, 39) == 0);
      ex_muldiv_start = ($urandom_range(0, 14) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_rd           = 5'($urandom_range(0, 3));
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_use_rs       = 1'($urandom_range(0, 1));
      id_use_rt       = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp = model_out();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b want %b", i, obs, exp);
      end
      tick();
    end
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_branch_lu();
    test_muldiv();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
